// File: rtl/inst_prefetch_buffer.sv
// rtl/inst_prefetch_buffer.sv - sequential instruction prefetch queue between RV32E fetch port and instruction memory
// Hides memory latency with an in-order prefetch queue; redirects flush it and drain stale responses.
module inst_prefetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] core_addr,
    output logic [31:0] core_inst,
    output logic        core_ready,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    // Discard can exceed DEPTH after back-to-back redirects, so give it headroom.
    localparam int unsigned DW = CW + 4;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]      q_data [DEPTH];
    logic [DEPTH-1:0] q_valid;
    logic [PW-1:0]    head_ptr;
    logic [PW-1:0]    tail_ptr;
    logic [CW-1:0]    occupancy;
    logic [CW-1:0]    outstanding;
    logic [DW-1:0]    discard;
    logic [31:0]      head_addr;
    logic [31:0]      fetch_addr;

    logic             head_valid;
    logic             hit;
    logic             redirect;
    logic             drop_resp;
    logic             live_resp;
    logic             push;
    logic             grant;
    logic [CW:0]      inflight;
    logic [DW-1:0]    discard_dec;
    logic [DW-1:0]    discard_redirect;

    always_comb begin
        tail_ptr   = head_ptr + occupancy[PW-1:0];
        head_valid = q_valid[head_ptr];
        hit        = head_valid && (core_addr == head_addr);
        redirect   = (core_addr != head_addr) &&
                     !((occupancy == '0) && (core_addr == fetch_addr));
        drop_resp  = mem_rvalid && (discard != '0);
        live_resp  = mem_rvalid && (discard == '0) && (outstanding != '0);
        push       = live_resp && !redirect;
        // A hit this cycle frees its slot in time for a same-cycle request.
        inflight   = {1'b0, occupancy} + {1'b0, outstanding} - {{CW{1'b0}}, hit};
        mem_req    = !rst && (redirect || (inflight < DEPTH_W));
        mem_addr   = redirect ? core_addr : fetch_addr;
        grant      = mem_req && mem_gnt;
        discard_dec      = discard - DW'(drop_resp);
        // A live response landing with the redirect is already accounted for.
        discard_redirect = discard_dec + DW'(outstanding) - DW'(live_resp);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_data[tail_ptr] <= mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_valid     <= '0;
            head_ptr    <= '0;
            occupancy   <= '0;
            outstanding <= '0;
            discard     <= '0;
            head_addr   <= '0;
            fetch_addr  <= '0;
            core_ready  <= 1'b0;
            core_inst   <= NOP_INST;
        end else begin
            core_ready <= hit;
            core_inst  <= hit ? q_data[head_ptr] : NOP_INST;
            if (redirect) begin
                q_valid     <= '0;
                head_ptr    <= '0;
                occupancy   <= '0;
                head_addr   <= core_addr;
                discard     <= discard_redirect;
                outstanding <= grant ? CW'(1) : '0;
                fetch_addr  <= grant ? core_addr + 32'd4 : core_addr;
            end else begin
                if (push) begin
                    q_valid[tail_ptr] <= 1'b1;
                end
                if (hit) begin
                    q_valid[head_ptr] <= 1'b0;
                    head_ptr          <= head_ptr + PW'(1);
                    head_addr         <= head_addr + 32'd4;
                end
                occupancy   <= occupancy + CW'(push) - CW'(hit);
                outstanding <= outstanding + CW'(grant) - CW'(push);
                discard     <= discard_dec;
                if (grant) begin
                    fetch_addr <= fetch_addr + 32'd4;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// tb/tb_inst_prefetch_buffer.sv - directed vector bench for inst_prefetch_buffer
module tb_inst_prefetch_buffer;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] core_addr;
    logic [31:0] core_inst;
    logic        core_ready;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    inst_prefetch_buffer #(.DEPTH(4), .NOP_INST(NOP)) dut (
        .clk        (clk),
        .rst        (rst),
        .core_addr  (core_addr),
        .core_inst  (core_inst),
        .core_ready (core_ready),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } pend_t;

    typedef struct {
        logic        r;
        logic [31:0] a;
        logic        g;
        logic        er;
        logic [31:0] ema;
        logic        erdy;
        logic [31:0] ei;
    } vec_t;

    pend_t       pend[$];
    vec_t        tbl [15];
    int unsigned cyc;
    int          n_vec;
    int          n_err;
    logic        s_req;
    logic [31:0] s_maddr;
    logic        s_ready;
    logic [31:0] s_inst;
    logic        resp;

    function automatic logic [31:0] mw(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic erdy, input logic [31:0] ei);
        chk({nm, "_ready"}, {31'd0, s_ready}, {31'd0, erdy});
        chk({nm, "_inst"}, s_inst, ei);
    endtask

    task automatic chk_req(input string nm, input logic er, input logic [31:0] ema);
        chk({nm, "_req"}, {31'd0, s_req}, {31'd0, er});
        if (er) chk({nm, "_addr"}, s_maddr, ema);
    endtask

    // One clock: drive inputs, sample combinational request, clock, sample registered outputs.
    task automatic step(input logic r, input logic [31:0] a, input logic g, input int unsigned lat);
        rst       = r;
        core_addr = a;
        mem_gnt   = g;
        resp      = (pend.size() > 0) && (pend[0].due <= cyc);
        mem_rvalid = resp;
        mem_rdata  = resp ? mw(pend[0].addr) : 32'h0;
        #2;
        s_req   = mem_req;
        s_maddr = mem_addr;
        @(posedge clk);
        if (resp) void'(pend.pop_front());
        if (s_req && g) pend.push_back('{addr: s_maddr, due: cyc + lat});
        cyc++;
        #1;
        s_ready = core_ready;
        s_inst  = core_inst;
    endtask

    task automatic restart();
        int n;
        n = 0;
        do begin
            step(1'b1, 32'h0, 1'b0, 1);
            n++;
        end while (pend.size() != 0 && n < 32);
        chk("drain", pend.size(), 0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        rst = 1'b1; core_addr = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        tbl[0]  = '{1'b1, 32'h100, 1'b1, 1'b0, 32'h0,   1'b0, NOP};
        tbl[1]  = '{1'b0, 32'h100, 1'b1, 1'b1, 32'h100, 1'b0, NOP};
        tbl[2]  = '{1'b0, 32'h100, 1'b1, 1'b1, 32'h104, 1'b0, NOP};
        tbl[3]  = '{1'b0, 32'h100, 1'b1, 1'b1, 32'h108, 1'b1, mw(32'h100)};
        tbl[4]  = '{1'b0, 32'h104, 1'b1, 1'b1, 32'h10C, 1'b1, mw(32'h104)};
        tbl[5]  = '{1'b0, 32'h108, 1'b1, 1'b1, 32'h110, 1'b1, mw(32'h108)};
        tbl[6]  = '{1'b0, 32'h10C, 1'b0, 1'b1, 32'h114, 1'b1, mw(32'h10C)};
        tbl[7]  = '{1'b0, 32'h110, 1'b0, 1'b1, 32'h114, 1'b1, mw(32'h110)};
        tbl[8]  = '{1'b0, 32'h114, 1'b0, 1'b1, 32'h114, 1'b0, NOP};
        tbl[9]  = '{1'b0, 32'h114, 1'b0, 1'b1, 32'h114, 1'b0, NOP};
        tbl[10] = '{1'b0, 32'h114, 1'b0, 1'b1, 32'h114, 1'b0, NOP};
        tbl[11] = '{1'b0, 32'h114, 1'b1, 1'b1, 32'h114, 1'b0, NOP};
        tbl[12] = '{1'b0, 32'h114, 1'b1, 1'b1, 32'h118, 1'b0, NOP};
        tbl[13] = '{1'b0, 32'h114, 1'b1, 1'b1, 32'h11C, 1'b1, mw(32'h114)};
        tbl[14] = '{1'b0, 32'h118, 1'b1, 1'b1, 32'h120, 1'b1, mw(32'h118)};

        @(posedge clk);
        #1;

        // Zero-wait streaming, then a five-cycle grant stall.
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].r, tbl[i].a, tbl[i].g, 1);
            chk_req($sformatf("tbl%0d", i), tbl[i].er, tbl[i].ema);
            chk_out($sformatf("tbl%0d", i), tbl[i].erdy, tbl[i].ei);
        end

        // Redirect with three requests in flight.
        restart();
        step(1'b0, 32'h300, 1'b1, 4);
        step(1'b0, 32'h300, 1'b1, 4);
        step(1'b0, 32'h300, 1'b1, 4);
        step(1'b0, 32'h200, 1'b1, 4);
        chk_req("redir", 1'b1, 32'h200);
        chk_out("redir", 1'b0, NOP);
        step(1'b0, 32'h200, 1'b1, 4); chk_out("redir_drop1", 1'b0, NOP);
        step(1'b0, 32'h200, 1'b1, 4); chk_out("redir_drop2", 1'b0, NOP);
        step(1'b0, 32'h200, 1'b1, 4); chk_out("redir_drop3", 1'b0, NOP);
        step(1'b0, 32'h200, 1'b1, 4);
        chk_req("redir_full", 1'b0, 32'h0);
        chk_out("redir_wait", 1'b0, NOP);
        step(1'b0, 32'h200, 1'b1, 4);
        chk_req("redir_hitreq", 1'b1, 32'h210);
        chk_out("redir_first", 1'b1, mw(32'h200));
        step(1'b0, 32'h204, 1'b1, 4);
        chk_out("redir_second", 1'b1, mw(32'h204));

        // Redirect in the same cycle as a live response.
        restart();
        step(1'b0, 32'h400, 1'b1, 2);
        step(1'b0, 32'h400, 1'b1, 2);
        step(1'b0, 32'h400, 1'b1, 2);
        step(1'b0, 32'h500, 1'b1, 2);
        chk_req("coinc", 1'b1, 32'h500);
        chk_out("coinc", 1'b0, NOP);
        step(1'b0, 32'h500, 1'b1, 2); chk_out("coinc_drop", 1'b0, NOP);
        step(1'b0, 32'h500, 1'b1, 2); chk_out("coinc_wait", 1'b0, NOP);
        step(1'b0, 32'h500, 1'b1, 2); chk_out("coinc_first", 1'b1, mw(32'h500));

        // Backpressure: core waits while slow memory fills all slots.
        restart();
        step(1'b0, 32'h600, 1'b1, 8);
        step(1'b0, 32'h600, 1'b1, 8);
        step(1'b0, 32'h600, 1'b1, 8);
        step(1'b0, 32'h600, 1'b1, 8);
        chk_req("fill4", 1'b1, 32'h60C);
        step(1'b0, 32'h600, 1'b1, 8); chk_req("full_a", 1'b0, 32'h0);
        step(1'b0, 32'h600, 1'b1, 8);
        step(1'b0, 32'h600, 1'b1, 8);
        step(1'b0, 32'h600, 1'b1, 8);
        step(1'b0, 32'h600, 1'b1, 8);
        chk_req("full_b", 1'b0, 32'h0);
        chk_out("full_wait", 1'b0, NOP);
        step(1'b0, 32'h600, 1'b1, 8);
        chk_req("full_hit", 1'b1, 32'h610);
        chk_out("full_hit", 1'b1, mw(32'h600));

        // Reset mid-stream with two late responses.
        restart();
        step(1'b0, 32'h700, 1'b1, 3);
        step(1'b0, 32'h700, 1'b1, 3);
        step(1'b1, 32'h700, 1'b1, 3);
        chk_req("mrst", 1'b0, 32'h0);
        chk_out("mrst", 1'b0, NOP);
        step(1'b0, 32'h0, 1'b0, 1);
        chk_req("mrst_late1", 1'b1, 32'h0);
        chk_out("mrst_late1", 1'b0, NOP);
        step(1'b0, 32'h0, 1'b0, 1); chk_out("mrst_late2", 1'b0, NOP);
        step(1'b0, 32'h0, 1'b1, 1); chk_out("mrst_gnt", 1'b0, NOP);
        step(1'b0, 32'h0, 1'b0, 1);
        chk_req("mrst_next", 1'b1, 32'h4);
        chk_out("mrst_push", 1'b0, NOP);
        step(1'b0, 32'h0, 1'b0, 1); chk_out("mrst_fresh", 1'b1, mw(32'h0));

        // Address wrap at the top of the address space.
        restart();
        step(1'b0, 32'hFFFF_FFFC, 1'b1, 1);
        chk_req("wrap", 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 32'hFFFF_FFFC, 1'b1, 1);
        chk_req("wrap_next", 1'b1, 32'h0);
        step(1'b0, 32'hFFFF_FFFC, 1'b1, 1);
        chk_out("wrap_top", 1'b1, mw(32'hFFFF_FFFC));
        step(1'b0, 32'h0, 1'b1, 1);
        chk_out("wrap_zero", 1'b1, mw(32'h0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
